// File: rtl/adder_pipe_pkg.sv
// Shared types and configuration limits for the pipelined adder/subtractor/accumulator.
package adder_pipe_pkg;

    localparam int WIDTH_MIN  = 8;
    localparam int WIDTH_MAX  = 64;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } adder_op_e;

    // Width-independent part of a stage payload; the core prepends the WIDTH-bit sum.
    typedef struct packed {
        logic      carry;
        logic      ovf;
        adder_op_e op;
    } adder_flags_t;

endpackage

// File: rtl/adder_pipe_if.sv
// Request/result handshake bundle between the adder agent and adder_pipe_core.
interface adder_pipe_if
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) ();
    logic             in_valid;
    logic             in_ready;
    adder_op_e        in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_carry;
    logic             out_ovf;
    adder_op_e        out_op;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_sum, out_carry, out_ovf, out_op
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_sum, out_carry, out_ovf, out_op
    );
endinterface

// File: rtl/adder_pipe_stage.sv
// One valid+payload register slice; holds everything (bubbles included) while en_i is low.
module adder_pipe_stage #(
    parameter type payload_t = logic
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en_i,
    input  logic     valid_i,
    input  payload_t data_i,
    output logic     valid_o,
    output payload_t data_o
);
    logic     valid_d, valid_q;
    payload_t data_d, data_q;

    // Payload only loads on a valid slot so the outputs keep the last result during bubbles.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (en_i) begin
            valid_d = valid_i;
            if (valid_i) begin
                data_d = data_i;
            end
        end
    end

    // NOTE: state registers use non-blocking assignment so every slice samples
    // its neighbour's pre-edge value; blocking here would collapse the pipeline.
    // NOTE: payload is reset too, because result outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
endmodule

// File: rtl/adder_pipe_core.sv
// Pipelined adder/subtractor with running accumulator; arithmetic and acc sit in stage 1,
// followed by STAGES register slices under a single global stall.
module adder_pipe_core
    import adder_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input logic         clk,
    input logic         rst,
    adder_pipe_if.slave bus
);
    localparam int             MSB = WIDTH - 1;
    localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

    // An out-of-range build never accepts work instead of producing wrong widths.
    localparam bit CFG_OK = (WIDTH >= WIDTH_MIN) && (WIDTH <= WIDTH_MAX) &&
                            (STAGES >= STAGES_MIN) && (STAGES <= STAGES_MAX);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        adder_flags_t     flags;
    } payload_t;

    logic             advance;
    logic             accept;
    logic [WIDTH:0]   res;
    logic             ovf;
    logic [WIDTH-1:0] acc_d, acc_q;
    payload_t         s1_pay;

    logic             v [1:STAGES];
    payload_t         p [1:STAGES];

    assign advance      = !v[STAGES] || bus.out_ready;
    assign bus.in_ready = CFG_OK && advance && !rst;
    assign accept       = bus.in_valid && bus.in_ready;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        res   = '0;
        ovf   = 1'b0;
        acc_d = acc_q;
        case (bus.in_op)
            OP_ADD: begin
                res = {1'b0, bus.in_a} + {1'b0, bus.in_b};
                ovf = (bus.in_a[MSB] == bus.in_b[MSB]) && (res[MSB] != bus.in_a[MSB]);
            end
            OP_SUB: begin
                res = {1'b0, bus.in_a} + {1'b0, ~bus.in_b} + ONE;
                ovf = (bus.in_a[MSB] != bus.in_b[MSB]) && (res[MSB] != bus.in_a[MSB]);
            end
            OP_ACC: begin
                res = {1'b0, acc_q} + {1'b0, bus.in_a};
                ovf = (acc_q[MSB] == bus.in_a[MSB]) && (res[MSB] != acc_q[MSB]);
                if (accept) begin
                    acc_d = res[WIDTH-1:0];
                end
            end
            OP_CLR: begin
                if (accept) begin
                    acc_d = '0;
                end
            end
            default: begin
                res = '0;
            end
        endcase

        s1_pay.sum         = res[WIDTH-1:0];
        s1_pay.flags.carry = res[WIDTH];
        s1_pay.flags.ovf   = ovf;
        s1_pay.flags.op    = bus.in_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    for (genvar i = 1; i <= STAGES; i++) begin : g_stage
        if (i == 1) begin : g_first
            adder_pipe_stage #(.payload_t(payload_t)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (advance),
                .valid_i (accept),
                .data_i  (s1_pay),
                .valid_o (v[i]),
                .data_o  (p[i])
            );
        end else begin : g_next
            adder_pipe_stage #(.payload_t(payload_t)) u_stage (
                .clk     (clk),
                .rst     (rst),
                .en_i    (advance),
                .valid_i (v[i-1]),
                .data_i  (p[i-1]),
                .valid_o (v[i]),
                .data_o  (p[i])
            );
        end
    end

    assign bus.out_valid = v[STAGES];
    assign bus.out_sum   = p[STAGES].sum;
    assign bus.out_carry = p[STAGES].flags.carry;
    assign bus.out_ovf   = p[STAGES].flags.ovf;
    assign bus.out_op    = p[STAGES].flags.op;
endmodule

// File: tb/tb_adder_pipe_core.sv
// Directed bench for adder_pipe_core at WIDTH=32, STAGES=2: vector table plus stall,
// accumulate-chain and mid-flight reset sequences.
module tb_adder_pipe_core;
    import adder_pipe_pkg::*;

    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int NVEC   = 14;

    typedef struct {
        adder_op_e   op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        carry;
        logic        ovf;
        adder_op_e   op;
        int          cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_cnt  = 0;
    res_t got_q [$];
    vec_t vecs [NVEC];

    adder_op_e   b_op  [4] = '{OP_CLR, OP_ACC, OP_ACC, OP_ACC};
    logic [31:0] b_a   [4] = '{32'h0000_1234, 32'd10, 32'd20, 32'hFFFF_FFF0};
    logic [31:0] b_exp [4] = '{32'h0, 32'd10, 32'd30, 32'h0000_000E};

    always #5 clk = ~clk;

    adder_pipe_if #(.WIDTH(WIDTH)) bus_if ();

    adder_pipe_core #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Record every result the downstream side actually consumes.
    always @(negedge clk) begin
        if (!rst && bus_if.out_valid && bus_if.out_ready) begin
            got_q.push_back('{bus_if.out_sum, bus_if.out_carry, bus_if.out_ovf,
                              bus_if.out_op, cyc_cnt});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input adder_op_e op, input logic [31:0] a, input logic [31:0] b);
        bus_if.in_op = op;
        bus_if.in_a  = a;
        bus_if.in_b  = b;
    endtask

    task automatic idle();
        bus_if.in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] sa(input int k);
        return 32'(32'h0100_0000 * (k + 1) + 32'h10);
    endfunction

    function automatic logic [31:0] sb(input int k);
        return 32'(k * 7);
    endfunction

    // Entered just after a rising edge; returns just after the edge that shows the result.
    task automatic run_single(input vec_t v, input string tag);
        int lat;
        drive(v.op, v.a, v.b);
        bus_if.in_valid = 1'b1;
        #1;
        check({tag, " in_ready"}, 64'(bus_if.in_ready), 64'(1'b1));
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        lat = 1;
        while (!bus_if.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'(STAGES));
        check({tag, " sum"},     64'(bus_if.out_sum),   64'(v.sum));
        check({tag, " carry"},   64'(bus_if.out_carry), 64'(v.carry));
        check({tag, " ovf"},     64'(bus_if.out_ovf),   64'(v.ovf));
        check({tag, " op"},      64'(bus_if.out_op),    64'(v.op));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   k;
        logic took;
        vec_t v;

        vecs[0]  = '{OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[1]  = '{OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[2]  = '{OP_SUB, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1'b0, 1'b0};
        vecs[3]  = '{OP_SUB, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1};
        vecs[4]  = '{OP_SUB, 32'h0000_0007, 32'h0000_0007, 32'h0000_0000, 1'b1, 1'b0};
        vecs[5]  = '{OP_ADD, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6]  = '{OP_ADD, 32'h0000_1234, 32'h0000_0001, 32'h0000_1235, 1'b0, 1'b0};
        vecs[7]  = '{OP_CLR, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 1'b0};
        vecs[8]  = '{OP_ACC, 32'h0000_0005, 32'hFFFF_FFFF, 32'h0000_0005, 1'b0, 1'b0};
        vecs[9]  = '{OP_ACC, 32'h7FFF_FFFB, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1};
        vecs[10] = '{OP_ACC, 32'h8000_0000, 32'h1234_5678, 32'h0000_0000, 1'b1, 1'b1};
        vecs[11] = '{OP_ACC, 32'h0000_0003, 32'h0000_0000, 32'h0000_0003, 1'b0, 1'b0};
        vecs[12] = '{OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[13] = '{OP_CLR, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0};

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        drive(OP_ADD, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(bus_if.in_ready),  64'(1'b0));
        check("reset out_valid", 64'(bus_if.out_valid), 64'(1'b0));
        check("reset out_sum",   64'(bus_if.out_sum),   64'(32'h0));
        check("reset out_carry", 64'(bus_if.out_carry), 64'(1'b0));
        check("reset out_ovf",   64'(bus_if.out_ovf),   64'(1'b0));
        check("reset out_op",    64'(bus_if.out_op),    64'(OP_ADD));
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < NVEC; i++) begin
            run_single(vecs[i], $sformatf("vec%0d", i));
        end

        // Back-to-back accumulate chain: each ACC sees the previous update.
        idle();
        got_q.delete();
        for (int i = 0; i < 4; i++) begin
            drive(b_op[i], b_a[i], 32'hFFFF_0000);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        for (int t = 0; t < 20 && got_q.size() < 4; t++) begin
            @(posedge clk); #1;
        end
        check("acc chain count", 64'(got_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("acc chain sum%0d", i), 64'(got_q[i].sum), 64'(b_exp[i]));
                check($sformatf("acc chain cycle%0d", i),
                      64'(got_q[i].cyc - got_q[0].cyc), 64'(i));
            end
        end
        if (got_q.size() == 4) begin
            check("acc chain last carry", 64'(got_q[3].carry), 64'(1'b1));
            check("acc chain last ovf",   64'(got_q[3].ovf),   64'(1'b0));
        end

        // Six ADDs against a 5-cycle downstream stall.
        idle();
        got_q.delete();
        bus_if.out_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 60 && k < 6; c++) begin
            if (c == 5) bus_if.out_ready = 1'b1;
            drive(OP_ADD, sa(k), sb(k));
            bus_if.in_valid = 1'b1;
            #1;
            if (c == 2) check("stall held count", 64'(k), 64'(2));
            if (c >= 2 && c < 5) begin
                check($sformatf("stall c%0d in_ready", c),  64'(bus_if.in_ready),  64'(1'b0));
                check($sformatf("stall c%0d out_valid", c), 64'(bus_if.out_valid), 64'(1'b1));
                check($sformatf("stall c%0d out_sum", c),   64'(bus_if.out_sum),
                      64'(32'h0100_0010));
            end
            took = bus_if.in_ready;
            @(posedge clk); #1;
            if (took) k++;
        end
        bus_if.in_valid = 1'b0;
        for (int t = 0; t < 30 && got_q.size() < 6; t++) begin
            @(posedge clk); #1;
        end
        repeat (3) @(posedge clk);
        #1;
        check("stall result count", 64'(got_q.size()), 64'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("stall result%0d", i), 64'(got_q[i].sum), 64'(sa(i) + sb(i)));
            end
        end

        // Reset with two ops in flight and acc=30.
        idle();
        for (int i = 0; i < 3; i++) begin
            drive(b_op[i], b_a[i], 32'h0);
            bus_if.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        bus_if.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        got_q.delete();
        drive(OP_ADD, 32'h1, 32'h2);
        bus_if.in_valid = 1'b1;
        @(posedge clk); #1;
        drive(OP_ADD, 32'h3, 32'h4);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("mid rst in_ready", 64'(bus_if.in_ready), 64'(1'b0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid rst out_valid", 64'(bus_if.out_valid), 64'(1'b0));
        check("mid rst out_sum",   64'(bus_if.out_sum),   64'(32'h0));
        repeat (2) @(posedge clk);
        #1;
        check("mid rst no output", 64'(got_q.size()), 64'(0));
        v = '{OP_ACC, 32'h0000_0001, 32'h0000_0055, 32'h0000_0001, 1'b0, 1'b0};
        run_single(v, "post rst acc");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/adder_pipe_core.md
# adder_pipe_core

Parametrised, pipelined 2-operand adder/subtractor with a running accumulator and valid/ready handshakes on both sides. It is the next-generation DUT for the adder verification environment. It replaces the fixed 32-bit combinational adder with configurable width, configurable latency, backpressure and an accumulate mode. The input side connects to the adder agent's driver. The output side connects to the monitor and scoreboard.

## Interface
- WIDTH, 32: operand/result width in bits, legal range 8..64.
- STAGES, 2: latency in cycles from input accept to output valid, legal range 1..4.
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operation presented.
- in_ready  out  1  core can accept this cycle.
- in_op  in  2  operation code: ADD=0, SUB=1, ACC=2, CLR=3.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B. Ignored for ACC and CLR.
- out_valid  out  1  result presented.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  WIDTH  result.
- out_carry  out  1  carry-out of the unsigned add.
- out_ovf  out  1  signed two's-complement overflow.
- out_op  out  2  op code that produced this result.

## Operation
- The input is accepted when in_valid && in_ready. The output is consumed when out_valid && out_ready.
- Arithmetic is evaluated in stage 1, in the cycle of acceptance, on WIDTH+1 bits. Stages 2..STAGES are pure register slices.
- ADD: {carry, sum} = a + b. ovf = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]).
- SUB: {carry, sum} = a + ~b + 1. carry=1 means no borrow. ovf = (a[MSB] != b[MSB]) && (sum[MSB] != a[MSB]).
- ACC: {carry, sum} = acc + a. acc <= sum. ovf uses the ADD rule with acc as the first operand.
- CLR: acc <= 0. Result: sum=0, carry=0, ovf=0.
- The internal acc register (WIDTH bits) updates only on an accepted ACC or CLR. Carry and overflow are reported, not stored, and acc wraps modulo 2^WIDTH.
- Back-to-back ACC ops see each other's update with no hazard, because acc is read and written in the same stage.
- Results leave strictly in acceptance order. Nothing is dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_sum=0, out_carry=0, out_ovf=0, out_op=0, acc=0, all stage valid bits 0.
- in_ready=0 while rst=1.
- Stall rule is a global stall: advance = !v[STAGES] || out_ready; in_ready = advance && !rst.
- When advance=0, every stage holds its contents, including bubbles, and outputs are stable.
- Latency: result accepted at cycle N appears with out_valid=1 at cycle N+STAGES, provided there is no stall.
- Throughput: one op per cycle when out_ready=1.
- Full pipe with out_ready=1: accept and emit in the same cycle, and the pipeline stays full.
- Full pipe with out_ready=0: in_ready=0 in the same cycle, combinationally.
- A bubble (in_valid=0 while advance=1) advances as an invalid slot.
- rst asserted mid-operation: all in-flight results are discarded. The next cycle shows out_valid=0 and acc=0, with no partial output.
- Payload outputs are don't-care-stable: they hold their last value when out_valid=0.

## Structure
- Package adder_pipe_pkg holds:
  - the op enum adder_op_e (ADD, SUB, ACC, CLR);
  - the stage payload struct (sum, carry, ovf, op);
  - localparams for the WIDTH and STAGES legal ranges.
- The global package's agent/scoreboard enables and DELAY remain separate.
- Sub-module adder_pipe_stage: one valid+payload register slice with an enable (advance) and synchronous reset. The core instantiates it STAGES times via generate.
- The arithmetic and the acc register live in adder_pipe_core itself.

## Test plan
All scenarios use WIDTH=32, STAGES=2.
- ADD 0xFFFF_FFFF + 0x1 -> sum 0x0, carry 1, ovf 0, out_valid exactly 2 cycles after accept.
- ADD 0x7FFF_FFFF + 0x1 -> sum 0x8000_0000, carry 0, ovf 1.
- SUB 5 - 7 -> sum 0xFFFF_FFFE, carry 0, ovf 0.
- SUB 0x8000_0000 - 1 -> sum 0x7FFF_FFFF, ovf 1.
- Back-to-back CLR, ACC 10, ACC 20, ACC 0xFFFF_FFF0 -> sums 0, 10, 30, 0x0000_000E. Carry on the last result = 1.
- Stream of 6 ADDs with out_ready held low for 5 cycles:
  - in_ready drops once 2 results are held;
  - after release, all 6 results are in order with no loss or duplication;
  - out_sum is stable during the stall.
- rst pulsed for 1 cycle with 2 ops in flight and acc=30 -> out_valid=0 the next cycle, and a following ACC 1 returns 1.
